rca_seq_adder: RTL



---
 rtl/rca_seq_adder_pkg.sv | 19 +
 rtl/rca_seq_adder_rca4bit.sv | 22 ++
 rtl/rca_seq_adder.sv | 98 +++++++++
 3 files changed

// File: rtl/rca_seq_adder_pkg.sv
// Shared constants and types for the nibble-serial ripple-carry adder.
// The counter-width helper keeps a 1-bit counter even for a single-slice build.
package rca_seq_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int nibbles);
    int w;
    w = $clog2(nibbles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rca_seq_adder_rca4bit.sv
// Existing 4-bit ripple-carry adder slice, purely combinational.
// The carry chain is built from four full-adder cells.
module RCA4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[4];

endmodule

// File: rtl/rca_seq_adder.sv
// Multi-cycle wide adder: one 4-bit RCA time-shared over NIBBLES slices, LSB first,
// with the carry chained through a register and valid/ready handshakes on both sides.
module rca_seq_adder
  import rca_seq_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      c_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                      c_out,
  output logic                      busy
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = cnt_width(NIBBLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    opa_q, opb_q;
  logic            carry_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;

  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic [W+NIBBLE_W-1:0] sum_shift;

  RCA4Bit u_rca (
    .a     (opa_q[NIBBLE_W-1:0]),
    .b     (opb_q[NIBBLE_W-1:0]),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  // New slice enters at the MSB end; after NIBBLES shifts slice 0 lands at [3:0].
  assign sum_shift = {slice_sum, sum_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)            state_d = ST_ADD;
      ST_ADD:  if (cnt_q == LAST_CNT)   state_d = ST_DONE;
      ST_DONE: if (out_ready)           state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            opa_q   <= a;
            opb_q   <= b;
            carry_q <= c_in;
            cnt_q   <= '0;
          end
        end
        ST_ADD: begin
          sum_q   <= sum_shift[W+NIBBLE_W-1:NIBBLE_W];
          cout_q  <= slice_cout;
          carry_q <= slice_cout;
          opa_q   <= opa_q >> NIBBLE_W;
          opb_q   <= opb_q >> NIBBLE_W;
          cnt_q   <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decode registered state only.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ADD) || (state_q == ST_DONE);
  assign sum       = sum_q;
  assign c_out     = cout_q;

endmodule
